// File: rtl/tb_mem_pkg.sv
// Shared types and helpers for the testbench SRAM arbiter.
//   mem_req_t : one requester's access at the default bus widths (8-bit word
//               address, 64-bit data), as seen by the bridge and backdoor ports.
//   rr_next   : round-robin winner search, first requester with its request
//               bit set, scanning upward from ptr and wrapping at num_req-1.
package tb_mem_pkg;

  localparam int unsigned MaxReq       = 32;
  localparam int unsigned MaxReqW      = $clog2(MaxReq);
  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefDataWidth = 64;

  typedef struct packed {
    logic                      we;
    logic [DefAddrWidth-1:0]   addr;
    logic [DefDataWidth-1:0]   wdata;
    logic [DefDataWidth/8-1:0] be;
  } mem_req_t;

  // Scans downward so the last hit is the first requester at or above ptr.
  // The caller only uses the result when some request bit is set.
  function automatic int rr_next(int ptr, logic [MaxReq-1:0] reqs, int num_req);
    int winner;
    int idx;
    winner = 0;
    for (int i = MaxReq - 1; i >= 0; i--) begin
      if (i < num_req) begin
        idx = ptr + i;
        if (idx >= num_req) idx = idx - num_req;
        if (reqs[idx[MaxReqW-1:0]]) winner = idx;
      end
    end
    return winner;
  endfunction

endpackage

// File: rtl/tb_mem_rsp_pipe.sv
// Response tracker: a Depth-stage shift register of {valid, requester index}.
// Each grant enters at stage 0 and leaves as a one-hot rvalid Depth cycles later.
//   clk_i, rst_i : clock, asynchronous active-high reset (drops in-flight entries)
//   valid_i      : a grant was issued this cycle
//   idx_i        : index of the granted requester
//   rvalid_o     : one-hot response valid, zero when no response is due
module tb_mem_rsp_pipe
  import tb_mem_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned Depth  = 1,
  parameter int unsigned IdxW   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [IdxW-1:0]   idx_i,
  output logic [NumReq-1:0] rvalid_o
);

  logic [Depth-1:0] vld_q;
  logic [IdxW-1:0]  idx_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < Depth; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      idx_q[0] <= idx_i;
      for (int i = 1; i < Depth; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign rvalid_o = vld_q[Depth-1] ? (NumReq'(1) << idx_q[Depth-1]) : '0;

endmodule

// File: rtl/tb_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NumReq requesters
// (NumReq <= 32). Grant is combinational; each grant returns one rvalid pulse to
// its originator MemLatency cycles later; per-requester saturating grant counters.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_i/we_i/addr_i/wdata_i/be_i : packed per-requester access fields
//   gnt_o, rvalid_o       : one-hot (or zero) grant and response valid
//   rdata_o               : SRAM read data, qualified by rvalid_o
//   mem_*_o, mem_rdata_i  : SRAM port
//   gnt_cnt_o, cnt_clr_i  : packed grant counters and their synchronous clear
module tb_mem_arbiter
  import tb_mem_pkg::*;
#(
  parameter int unsigned NumReq     = 2,
  parameter int unsigned AddrWidth  = 8,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned MemLatency = 1,
  parameter int unsigned CntWidth   = 32,
  localparam int unsigned BeWidth   = DataWidth / 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_i,
  input  logic [NumReq-1:0]            we_i,
  input  logic [NumReq*AddrWidth-1:0]  addr_i,
  input  logic [NumReq*DataWidth-1:0]  wdata_i,
  input  logic [NumReq*BeWidth-1:0]    be_i,
  output logic [NumReq-1:0]            gnt_o,
  output logic [NumReq-1:0]            rvalid_o,
  output logic [DataWidth-1:0]         rdata_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [AddrWidth-1:0]         mem_addr_o,
  output logic [DataWidth-1:0]         mem_wdata_o,
  output logic [BeWidth-1:0]           mem_be_o,
  input  logic [DataWidth-1:0]         mem_rdata_i,
  output logic [NumReq*CntWidth-1:0]   gnt_cnt_o,
  input  logic                         cnt_clr_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [AddrWidth-1:0] addr_v  [NumReq];
  logic [DataWidth-1:0] wdata_v [NumReq];
  logic [BeWidth-1:0]   be_v    [NumReq];
  logic [CntWidth-1:0]  cnt_q   [NumReq];

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] win_idx;
  logic            any_req;

  for (genvar k = 0; k < NumReq; k++) begin : g_unpack
    assign addr_v[k]  = addr_i[k*AddrWidth +: AddrWidth];
    assign wdata_v[k] = wdata_i[k*DataWidth +: DataWidth];
    assign be_v[k]    = be_i[k*BeWidth +: BeWidth];
    assign gnt_cnt_o[k*CntWidth +: CntWidth] = cnt_q[k];
  end

  assign any_req = |req_i;

  always_comb begin
    win_idx     = IdxW'(rr_next(int'(ptr_q), MaxReq'(req_i), int'(NumReq)));
    gnt_o       = '0;
    mem_req_o   = any_req;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    ptr_d       = ptr_q;
    if (any_req) begin
      gnt_o       = NumReq'(1) << win_idx;
      mem_we_o    = we_i[win_idx];
      mem_addr_o  = addr_v[win_idx];
      mem_wdata_o = wdata_v[win_idx];
      mem_be_o    = be_v[win_idx];
      if (NumReq == 1 || win_idx == IdxW'(NumReq - 1)) ptr_d = '0;
      else                                             ptr_d = win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Clear takes precedence over a same-cycle grant; counters stick at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumReq; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        if (cnt_clr_i)                          cnt_q[k] <= '0;
        else if (gnt_o[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  tb_mem_rsp_pipe #(
    .NumReq (NumReq),
    .Depth  (MemLatency),
    .IdxW   (IdxW)
  ) u_rsp_pipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (any_req),
    .idx_i    (win_idx),
    .rvalid_o (rvalid_o)
  );

  assign rdata_o = mem_rdata_i;

endmodule
